// File: rtl/mem_req_arb_if.sv
// Requester and cache-port signal bundle for mem_req_arb.
// The arbiter uses the slave view; the surrounding pipeline/cache side uses master.
interface mem_req_arb_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_done;
  logic [DW-1:0] if_data;
  logic          if_stall;

  logic          dm_rd;
  logic          dm_wr;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_done;
  logic [DW-1:0] dm_rdata;
  logic          dm_stall;

  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_datain;
  logic [DW-1:0] mem_dataout;
  logic          mem_done;
  logic          mem_stall;
  logic          mem_hit;

  modport slave (
    input  if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata,
           mem_dataout, mem_done, mem_stall, mem_hit,
    output if_done, if_data, if_stall, dm_done, dm_rdata, dm_stall,
           mem_rd, mem_wr, mem_addr, mem_datain
  );

  modport master (
    output if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata,
           mem_dataout, mem_done, mem_stall, mem_hit,
    input  if_done, if_data, if_stall, dm_done, dm_rdata, dm_stall,
           mem_rd, mem_wr, mem_addr, mem_datain
  );
endinterface

// File: rtl/mem_req_arb.sv
// Shares one cache Rd/Wr port between fetch and data-memory requesters,
// one outstanding request at a time, with alternating priority and perf counters.
module mem_req_arb #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_req_arb_if.slave bus,
  output logic        err,
  output logic [15:0] req_cnt,
  output logic [15:0] hit_cnt
);

  typedef enum logic { IDLE, BUSY } state_t;
  typedef enum logic { OWN_IF, OWN_DM } own_t;

  state_t state, state_nxt;
  own_t   owner, last_grant;

  logic          if_cand, dm_cand;
  logic          grant_if, grant_dm, grant;
  logic          complete, stray_done, grant_err;
  logic [AW-1:0] sel_addr;

  // A requester is masked during its own done cycle so a held request is not re-issued.
  assign if_cand = bus.if_req & ~bus.if_done;
  assign dm_cand = (bus.dm_rd | bus.dm_wr) & ~bus.dm_done;

  assign bus.if_stall = bus.if_req & ~bus.if_done;
  assign bus.dm_stall = (bus.dm_rd | bus.dm_wr) & ~bus.dm_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == IDLE) begin
      if (grant) state_nxt = BUSY;
    end else begin
      if (bus.mem_done) state_nxt = IDLE;
    end
  end

  always_comb begin
    grant_if   = 1'b0;
    grant_dm   = 1'b0;
    complete   = 1'b0;
    stray_done = 1'b0;
    if (state == IDLE) begin
      stray_done = bus.mem_done;
      if (!bus.mem_stall) begin
        if (if_cand && dm_cand) begin
          grant_dm = (last_grant == OWN_IF);
          grant_if = (last_grant == OWN_DM);
        end else begin
          grant_if = if_cand;
          grant_dm = dm_cand;
        end
      end
    end else begin
      complete = bus.mem_done;
    end
  end

  assign grant     = grant_if | grant_dm;
  assign sel_addr  = grant_dm ? bus.dm_addr : bus.if_addr;
  assign grant_err = (grant_if & bus.if_addr[0]) |
                     (grant_dm & (bus.dm_addr[0] | (bus.dm_rd & bus.dm_wr)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_rd     <= 1'b0;
      bus.mem_wr     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_datain <= '0;
      bus.if_done    <= 1'b0;
      bus.if_data    <= '0;
      bus.dm_done    <= 1'b0;
      bus.dm_rdata   <= '0;
      owner          <= OWN_IF;
      last_grant     <= OWN_IF;
      err            <= 1'b0;
      req_cnt        <= '0;
      hit_cnt        <= '0;
    end else begin
      bus.if_done <= 1'b0;
      bus.dm_done <= 1'b0;

      // Grant: latch the winning request; a data rd+wr collision is issued as a write.
      if (grant) begin
        bus.mem_addr   <= {sel_addr[AW-1:1], 1'b0};
        bus.mem_rd     <= grant_if | (grant_dm & ~bus.dm_wr);
        bus.mem_wr     <= grant_dm & bus.dm_wr;
        bus.mem_datain <= (grant_dm & bus.dm_wr) ? bus.dm_wdata : '0;
        owner          <= grant_dm ? OWN_DM : OWN_IF;
      end

      // Completion: route read data to the owner and pulse its done.
      if (complete) begin
        bus.mem_rd <= 1'b0;
        bus.mem_wr <= 1'b0;
        last_grant <= owner;
        req_cnt    <= req_cnt + 16'd1;
        hit_cnt    <= hit_cnt + 16'(bus.mem_hit);
        if (owner == OWN_IF) begin
          bus.if_done <= 1'b1;
          bus.if_data <= bus.mem_dataout;
        end else begin
          bus.dm_done <= 1'b1;
          if (bus.mem_rd) bus.dm_rdata <= bus.mem_dataout;
        end
      end

      if (stray_done | grant_err) err <= 1'b1;
    end
  end

endmodule

// File: doc/mem_req_arb.md
# mem_req_arb

Two-port request arbiter that sits directly upstream of `mem_system_hier` and shares its single Rd/Wr port between the pipeline's instruction-fetch stage and data-memory stage. It latches one request at a time, drives the cache port with stable registered signals until `Done`, and routes the returned data to the granting requester with a one-cycle done pulse. It also maintains request and hit counters for performance reporting.

## Interface
- `AW`, 16, address width (matches cache `Addr`)
- `DW`, 16, data width (matches cache `DataIn`/`DataOut`)
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch read request, held until `if_done`
- `if_addr`  in  AW  fetch address
- `if_done`  out  1  one-cycle pulse, `if_data` valid
- `if_data`  out  DW  fetch read data, registered, holds until next fetch completion
- `if_stall`  out  1  `if_req & ~if_done`
- `dm_rd`, `dm_wr`  in  1  data read/write request, held until `dm_done`
- `dm_addr`  in  AW  data address
- `dm_wdata`  in  DW  write data
- `dm_done`  out  1  one-cycle pulse; `dm_rdata` valid on reads
- `dm_rdata`  out  DW  data read result, registered
- `dm_stall`  out  1  `(dm_rd|dm_wr) & ~dm_done`
- `mem_rd`, `mem_wr`  out  1  to cache `Rd`/`Wr`, registered
- `mem_addr`  out  AW  to cache `Addr`, registered, bit 0 always 0
- `mem_datain`  out  DW  to cache `DataIn`, registered
- `mem_dataout`  in  DW  from cache `DataOut`
- `mem_done`, `mem_stall`, `mem_hit`  in  1  from cache `Done`, `Stall`, `CacheHit`
- `err`  out  1  sticky protocol error flag
- `req_cnt`, `hit_cnt`  out  16  completed requests / completed hits

## Operation
- Async reset: all outputs 0, state IDLE, `last_grant`=fetch.
- States: IDLE, BUSY.
- IDLE: candidates are `if_req` (masked while `if_done`=1) and `dm_rd|dm_wr` (masked while `dm_done`=1). Grant only if `mem_stall`=0.
  - One candidate: grant it. Both: grant the port not equal to `last_grant` (data first after reset).
  - On grant: load `mem_addr` = addr with bit 0 cleared, `mem_rd`/`mem_wr`, `mem_datain` (=`dm_wdata` on data writes, else 0); record grant owner; -> BUSY.
- BUSY: hold all `mem_*` outputs constant. When `mem_done`=1 at a clock edge: clear `mem_rd`/`mem_wr`, capture `mem_dataout` into owner's data register (reads only; writes leave `dm_rdata` unchanged), pulse owner's done, `req_cnt`+=1, `hit_cnt`+=`mem_hit`, `last_grant`=owner, -> IDLE.
- `mem_done` in IDLE is ignored and sets `err`.
- `dm_rd` & `dm_wr` both high: treat as write, set `err`.
- Request address bit 0 = 1: issue with bit 0 cleared, set `err`.
- Counters wrap modulo 2^16. `err` clears only on reset.
- Reset during BUSY: request abandoned, no done pulse, `mem_rd`/`mem_wr` drop asynchronously.

## Timing
- Grant edge E0 (requester high, IDLE, `mem_stall`=0) -> `mem_rd|wr` high in cycle after E0.
- Cache hit (`mem_done` same cycle as request) -> done pulse in the next cycle: 2 cycles requester-to-done.
- Miss: done pulse one cycle after `mem_done`; `mem_*` stable for whole BUSY interval.
- Back-to-back: IDLE lasts exactly one cycle when the other port is pending (granted on the done-pulse edge's following edge); at most one outstanding request.
- `if_stall`/`dm_stall` combinational from inputs and registered done.

## Test plan
- Reset: `rst_n`=0 mid-BUSY -> `mem_rd`=0 immediately, all outputs 0, no `if_done` after release.
- Single fetch hit: `if_addr`=0x6004, `mem_done`=`mem_hit`=1 on first issued cycle -> `if_done` pulse 2 cycles after request, `if_data`=`mem_dataout`, `hit_cnt`=1.
- Data write miss: `dm_wr`, `dm_addr`=0x1232, `dm_wdata`=0xBEEF, `mem_done` 12 cycles later, `mem_hit`=0 -> `mem_addr`=0x1232, `mem_datain`=0xBEEF held 12 cycles, `dm_done` once, `req_cnt`=1, `hit_cnt`=0.
- Simultaneous requests after reset -> data granted first, fetch issued exactly one cycle after `dm_done`; no repeat of data request.
- Stall gating: both ports idle-pending with `mem_stall`=1 for 5 cycles -> `mem_rd`/`mem_wr` stay 0; grant on first cycle `mem_stall`=0.
- Errors: `dm_rd`=`dm_wr`=1 at addr 0x0003 -> write issued to 0x0002, `err`=1 and stays 1; stray `mem_done` in IDLE also sets `err`.
